// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared word/PC constants and fetch entry type for the MIPS front end
package mips_pkg;
  localparam int WORD_W     = 32;
  localparam int INST_BYTES = 4;
  localparam logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_INC       = 32'(INST_BYTES);

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~WORD_W'(INST_BYTES - 1);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush; head is read straight from registered storage
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  assign do_pop    = pop && (count_q != '0);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Flush wins over a same-cycle push or pop.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - credit-limited sequential fetch with redirect flush and stale-response drop
module instruction_fetch_queue
  import mips_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WORD_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [WORD_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] inst_data,
  output logic [WORD_W-1:0] inst_pc,
  output logic [WORD_W-1:0] inst_pc_plus4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              req_fire, push, pop;
  fetch_entry_t      push_entry, head_entry;

  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign pop            = inst_valid && inst_ready;
  assign push_entry     = {rsp_pc_q, imem_rsp_data};

  assign inst_valid    = !reset && (fifo_count != '0);
  assign inst_pc       = head_entry.pc;
  assign inst_data     = head_entry.inst;
  assign inst_pc_plus4 = head_entry.pc + PC_INC;

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      // Everything still in flight after this cycle is stale, whether or not it was already marked.
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
      if (push)     rsp_pc_d   = rsp_pc_q + PC_INC;
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  a_credit: assert property (@(posedge clock) disable iff (reset) credit_used <= (CW+1)'(DEPTH));
  a_drop:   assert property (@(posedge clock) disable iff (reset) drop_cnt_q <= outstanding_q);
  a_rsp:    assert property (@(posedge clock) disable iff (reset) imem_rsp_valid |-> outstanding_q != '0);
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - directed self-checking bench for instruction_fetch_queue
module tb_instruction_fetch_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  instruction_fetch_queue dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          pend_due[$];
  logic [31:0] pend_addr[$];
  logic        o_req, o_iv, o_acc;
  logic [31:0] o_addr, o_pc, o_data, o_p4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, model memory, sample outputs mid-cycle, then advance.
  task automatic step(input logic rdy, input logic irdy);
    int due;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (reset) begin
      pend_due.delete();
      pend_addr.delete();
      last_due = cyc;
    end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    #1;
    o_req  = imem_req_valid;
    o_addr = imem_req_addr;
    o_iv   = inst_valid;
    o_pc   = inst_pc;
    o_data = inst_data;
    o_p4   = inst_pc_plus4;
    o_acc  = imem_req_valid && rdy;
    if (o_acc) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      pend_due.push_back(due);
      pend_addr.push_back(imem_req_addr);
      last_due = due;
    end
    @(posedge clock);
    #1;
    cyc++;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_req_valid", o_req, 0);
    check("rst_inst_valid", o_iv, 0);
    check("rst_addr", o_addr, 32'h0);
    check("rst_inst_pc", o_pc, 32'h0);
    check("rst_inst_data", o_data, 32'h0);
    check("rst_pc_plus4", o_p4, 32'h4);
    reset = 1'b0;
  endtask

  task automatic wait_inst(input string tag);
    int k;
    k = 0;
    step(1'b1, 1'b1);
    while (!o_iv && k < 20) begin
      step(1'b1, 1'b1);
      k++;
    end
    check({tag, "_timeout"}, 32'(o_iv), 32'd1);
  endtask

  initial begin
    int acc;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;

    // 1: latency 1 streaming
    do_reset();
    lat = 1;
    step(1'b1, 1'b1);
    check("t1_first_req", o_req, 1);
    check("t1_first_addr", o_addr, 32'h0);
    check("t1_iv_after_rst", o_iv, 0);
    check("t1_pc_after_rst", o_pc, 32'h0);
    check("t1_p4_after_rst", o_p4, 32'h4);
    step(1'b1, 1'b1);
    check("t1_iv_lat", o_iv, 0);
    check("t1_addr1", o_addr, 32'h4);
    step(1'b1, 1'b1);
    check("t1_iv_first", o_iv, 1);
    check("t1_pc_first", o_pc, 32'h0);
    check("t1_p4_first", o_p4, 32'h4);
    check("t1_data_first", o_data, 32'hDEAD_0000);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1);
      check("t1_iv_stream", o_iv, 1);
      check("t1_pc_stream", o_pc, 32'(4 * k));
    end

    // 2: core stalled, latency 3 -> credit limit
    do_reset();
    lat = 3;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      if (o_acc) acc++;
    end
    check("t2_accepts", acc, 4);
    check("t2_req_stalled", o_req, 0);
    check("t2_iv_full", o_iv, 1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1);
      check("t2_iv_drain", o_iv, 1);
      check("t2_pc_drain", o_pc, 32'(4 * k));
      check("t2_data_drain", o_data, mem_word(32'(4 * k)));
      if (k == 1) begin
        check("t2_resume_req", o_req, 1);
        check("t2_resume_addr", o_addr, 32'h10);
      end
    end

    // 3: memory not ready -> request held
    do_reset();
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      check("t3_hold_valid", o_req, 1);
      check("t3_hold_addr", o_addr, 32'h0);
    end
    step(1'b1, 1'b1);
    check("t3_accept_addr", o_addr, 32'h0);
    step(1'b1, 1'b1);
    check("t3_next_addr", o_addr, 32'h4);

    // 4: redirect with two in flight
    do_reset();
    lat = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step(1'b1, 1'b1);
    check("t4_redir_no_req", o_req, 0);
    step(1'b1, 1'b1);
    check("t4_addr_20", o_addr, 32'h20);
    step(1'b1, 1'b1);
    check("t4_addr_24", o_addr, 32'h24);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step(1'b1, 1'b1);
    check("t4_redir2_no_req", o_req, 0);
    wait_inst("t4_wait");
    check("t4_pc_100", o_pc, 32'h100);
    check("t4_data_100", o_data, mem_word(32'h100));
    step(1'b1, 1'b1);
    check("t4_pc_104", o_pc, 32'h104);

    // 5: unaligned redirect, then redirect colliding with response and pop
    do_reset();
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("t5_req_200", o_req, 1);
    check("t5_addr_200", o_addr, 32'h200);
    wait_inst("t5_wait1");
    check("t5_pc_200", o_pc, 32'h200);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step(1'b1, 1'b1);
    check("t5_coll_iv", o_iv, 1);
    check("t5_coll_pc", o_pc, 32'h204);
    check("t5_coll_no_req", o_req, 0);
    step(1'b1, 1'b1);
    check("t5_flushed", o_iv, 0);
    check("t5_addr_300", o_addr, 32'h300);
    wait_inst("t5_wait2");
    check("t5_pc_300", o_pc, 32'h300);
    check("t5_data_300", o_data, mem_word(32'h300));

    // 6: PC wrap, then reset mid-stream
    do_reset();
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("t6_addr_top", o_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1);
    check("t6_addr_wrap", o_addr, 32'h0);
    wait_inst("t6_wait");
    check("t6_pc_top", o_pc, 32'hFFFF_FFFC);
    check("t6_p4_wrap", o_p4, 32'h0);
    step(1'b1, 1'b1);
    check("t6_pc_wrap", o_pc, 32'h0);
    reset = 1'b1;
    step(1'b1, 1'b1);
    check("t6_rst_iv", o_iv, 0);
    check("t6_rst_req", o_req, 0);
    step(1'b1, 1'b1);
    check("t6_rst2_iv", o_iv, 0);
    reset = 1'b0;
    step(1'b1, 1'b1);
    check("t6_post_iv", o_iv, 0);
    check("t6_post_addr", o_addr, 32'h0);
    wait_inst("t6_wait2");
    check("t6_post_pc", o_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
